// File: rtl/myproject_mac_pkg.sv
// Shared types and constants for the dense-layer MAC accumulator.
package myproject_mac_pkg;

  typedef enum logic [1:0] {ST_ACC, ST_RND, ST_OUT} state_t;

  localparam int N_IN_DEF       = 16;
  localparam int PROD_WIDTH_DEF = 30;
  localparam int ACC_WIDTH_DEF  = 38;
  localparam int OUT_WIDTH_DEF  = 16;
  localparam int FRAC_SHIFT_DEF = 10;

  // Smallest accumulator that can sum n_in products plus a bias without wrapping.
  function automatic int min_acc_width(input int n_in, input int prod_width);
    return prod_width + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation to OUT_WIDTH.
module myproject_round_sat
  import myproject_mac_pkg::*;
#(
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] data,
  output logic                        sat
);

  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(64'sd1 <<< (FRAC_SHIFT - 1));
  localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = ACC_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  function automatic logic signed [ACC_WIDTH-1:0] round_shift(input logic signed [ACC_WIDTH-1:0] a);
    return (a + HALF) >>> FRAC_SHIFT;
  endfunction

  // Returns {sat, data}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] r);
    if (r > MAXV)      return {1'b1, MAXV[OUT_WIDTH-1:0]};
    else if (r < MINV) return {1'b1, MINV[OUT_WIDTH-1:0]};
    else               return {1'b0, r[OUT_WIDTH-1:0]};
  endfunction

  logic signed [ACC_WIDTH-1:0] r;
  logic        [OUT_WIDTH:0]   res;

  always_comb begin
    r    = round_shift(acc);
    res  = saturate(r);
    sat  = res[OUT_WIDTH];
    data = res[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/myproject_mac_accum.sv
// Accumulates one group of signed products onto a scaled bias, then rounds,
// saturates and holds the activation until downstream accepts it.
module myproject_mac_accum
  import myproject_mac_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic signed [PROD_WIDTH-1:0] prod_i,
  input  logic                         prod_valid,
  input  logic                         prod_last,
  output logic                         prod_ready,
  input  logic signed [OUT_WIDTH-1:0]  bias_i,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sat,
  output logic                         len_err
);

  localparam int              CNT_W    = $clog2(N_IN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  state_t                      state, state_n;
  logic [CNT_W-1:0]            cnt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic signed [OUT_WIDTH-1:0] rs_data;
  logic                        rs_sat;
  logic                        accept, at_last, close;

  assign accept   = prod_valid && prod_ready;
  assign at_last  = (cnt == CNT_LAST);
  assign close    = accept && (at_last || prod_last);
  assign prod_ext = ACC_WIDTH'(prod_i);
  assign bias_ext = ACC_WIDTH'(bias_i);
  // The first product of a group starts from the bias moved to product scale.
  assign acc_base = (cnt == '0) ? (bias_ext <<< FRAC_SHIFT) : acc;

  myproject_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_round_sat (
    .acc (acc),
    .data(rs_data),
    .sat (rs_sat)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_ACC:  if (close) state_n = ST_RND;
      ST_RND:  state_n = ST_OUT;
      ST_OUT:  if (out_valid && out_ready) state_n = ST_ACC;
      default: state_n = ST_ACC;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= ST_ACC;
      prod_ready <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sat    <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_n;
      // Registered from the next state so input readiness never sees out_ready or prod_valid.
      prod_ready <= (state_n == ST_ACC);

      // Accumulate stage
      if (accept) begin
        acc <= acc_base + prod_ext;
        cnt <= close ? '0 : cnt + 1'b1;
        if (close && (prod_last != at_last)) len_err <= 1'b1;
      end

      // Round/saturate into the output register stage
      if (state == ST_RND) begin
        out_data  <= rs_data;
        out_sat   <= rs_sat;
        out_valid <= 1'b1;
      end else if (state == ST_OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_myproject_mac_accum.sv
// Scoreboard bench for myproject_mac_accum with N_IN=4, FRAC_SHIFT=10, OUT_WIDTH=16.
module tb_myproject_mac_accum;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [29:0] prod_i = '0;
  logic               prod_valid = 1'b0;
  logic               prod_last = 1'b0;
  logic               prod_ready;
  logic signed [15:0] bias_i = '0;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_sat;
  logic               len_err;

  always #5 clk = ~clk;

  myproject_mac_accum #(
    .N_IN(N), .PROD_WIDTH(30), .ACC_WIDTH(38), .OUT_WIDTH(16), .FRAC_SHIFT(10)
  ) dut (
    .ap_clk(clk), .ap_rst(rst),
    .prod_i(prod_i), .prod_valid(prod_valid), .prod_last(prod_last), .prod_ready(prod_ready),
    .bias_i(bias_i),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
    .len_err(len_err)
  );

  typedef struct {
    logic signed [15:0] data;
    logic               sat;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   rdy_mode = 0;  // 0: out_ready high, 1: random, 2: held low

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum, floor((sum + 512) / 1024), clamp to int16.
  function automatic exp_t model(input int bias, input int ps[$]);
    exp_t   e;
    longint s, t, q;
    s = longint'(bias) * 1024;
    foreach (ps[i]) s += longint'(ps[i]);
    t = s + 512;
    q = t / 1024;
    if ((t % 1024 != 0) && (t < 0)) q = q - 1;
    if (q > 32767) begin
      e.data = 16'sd32767; e.sat = 1'b1;
    end else if (q < -32768) begin
      e.data = -16'sd32768; e.sat = 1'b1;
    end else begin
      e.data = 16'(q); e.sat = 1'b0;
    end
    return e;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expectations on each output handshake and checks hold stability.
  logic signed [15:0] prev_data;
  logic               prev_sat;
  bit                 prev_hold = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && out_valid) begin
        check("hold_data", out_data, prev_data);
        check("hold_sat", out_sat, prev_sat);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out: got data %0d with empty scoreboard (t=%0t)", out_data, $time);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("out_data", out_data, e.data);
          check("out_sat", out_sat, e.sat);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_sat  = out_sat;
    end
  end

  task automatic send_prod(input int p, input bit last, input int bias);
    int w;
    prod_i     = 30'(p);
    prod_last  = last;
    bias_i     = 16'(bias);
    prod_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (prod_ready) break;
      w++;
      if (w > 200) begin
        tests++; fails++;
        $display("FAIL accept_timeout: prod_ready stayed %0d, expected 1", prod_ready);
        break;
      end
    end
    @(posedge clk); #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic send_group(input int bias, input int ps[$], input bit use_last, input bit gaps, input bit push);
    if (push) sbq.push_back(model(bias, ps));
    foreach (ps[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_prod(ps[i], use_last && (i == ps.size() - 1), bias);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sbq.size() != 0 || out_valid) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_pending", sbq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int w;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_len_err", len_err, 0);
    check("rst_prod_ready", prod_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", prod_ready, 1);

    // Basic group plus latency of the result.
    q = '{1024, 1024, 1024, 1024};
    sbq.push_back(model(0, q));
    for (int i = 0; i < N; i++) send_prod(q[i], i == N - 1, 0);
    check("lat_valid_at_accept", out_valid, 0);
    check("rnd_ready_low", prod_ready, 0);
    @(negedge clk);
    check("lat_valid_rnd", out_valid, 0);
    @(negedge clk);
    check("lat_valid_out", out_valid, 1);
    wait_idle();

    // Bias handling and consecutive groups.
    q = '{1024, 1024, 1024, 1024};
    send_group(3, q, 1'b1, 1'b0, 1'b1);
    q = '{0, 0, 0, 0};
    send_group(-2, q, 1'b1, 1'b0, 1'b1);

    // Rounding around the half point.
    q = '{512, 0, 0, 0};
    send_group(0, q, 1'b1, 1'b0, 1'b1);
    q = '{-512, 0, 0, 0};
    send_group(0, q, 1'b1, 1'b0, 1'b1);
    q = '{-513, 0, 0, 0};
    send_group(0, q, 1'b1, 1'b0, 1'b1);

    // Saturation in both directions.
    q = '{268435456, 268435456, 268435456, 268435456};
    send_group(0, q, 1'b1, 1'b0, 1'b1);
    q = '{-268435456, -268435456, -268435456, -268435456};
    send_group(0, q, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check("len_err_clean", len_err, 0);

    // Back-pressure: hold the result for 5 cycles.
    rdy_mode = 2;
    @(posedge clk); #2;
    q = '{2048, 1024, 1024, 1024};
    send_group(5, q, 1'b1, 1'b0, 1'b1);
    w = 0;
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    check("bp_valid_seen", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_ready_low", prod_ready, 0);
      check("bp_valid_held", out_valid, 1);
    end
    rdy_mode = 0;
    @(posedge clk); #2;
    check("bp_valid_before_accept", out_valid, 1);
    @(posedge clk); #1;
    check("bp_valid_after_accept", out_valid, 0);
    wait_idle();

    // Early last: two products only.
    q = '{2048, 1024};
    send_group(0, q, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check("len_err_early_last", len_err, 1);
    q = '{1024, 1024, 1024, 1024};
    send_group(1, q, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check("len_err_sticky", len_err, 1);

    // Randomized groups with gaps and random back-pressure.
    rdy_mode = 1;
    for (int g = 0; g < 40; g++) begin
      int n, bias, p;
      bit last;
      n = $urandom_range(1, N);
      q = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) p = int'($signed($urandom)) >>> 2;
        else p = int'($urandom_range(0, 2097152)) - 1048576;
        q.push_back(p);
      end
      bias = int'($signed(16'($urandom)));
      last = (n < N) ? 1'b1 : 1'($urandom_range(0, 1));
      send_group(bias, q, last, 1'b1, 1'b1);
    end
    rdy_mode = 0;
    wait_idle();

    // Reset in the middle of a group: nothing emitted, partial sum dropped.
    send_prod(100000, 1'b0, 7);
    send_prod(200000, 1'b0, 7);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_sat", out_sat, 0);
    check("mid_rst_len_err", len_err, 0);
    check("mid_rst_prod_ready", prod_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ready_back", prod_ready, 1);
    q = '{1024, 1024, 1024, 1024};
    send_group(0, q, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check("post_rst_len_err", len_err, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
